display_timing: RTL



---
 rtl/display_pkg.sv | 19 +
 rtl/axis_counter.sv | 30 +++
 rtl/display_timing.sv | 65 ++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared timing types, video mode presets and the default coordinate width.
package display_pkg;
  localparam int CORDW_DEFAULT = 16;
  typedef struct packed {
    int res;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;
  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } timing_t;
  localparam timing_t TIMING_640X480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam timing_t TIMING_1280X720_60 = '{h: '{1280, 110, 40, 220}, v: '{720, 5, 5, 20}};
  function automatic int axis_total(input axis_timing_t t);
    return t.res + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/axis_counter.sv
// axis_counter: one raster axis; wrap counter plus active and sync window decode of its next value.
module axis_counter import display_pkg::*; #(
  parameter int W    = CORDW_DEFAULT,
  parameter int RES  = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         act,
  output logic         win
);
  localparam logic [W-1:0] LAST    = W'(RES + FP + SYNC + BP - 1);
  localparam logic [W-1:0] ACT_END = W'(RES);
  localparam logic [W-1:0] SYNC_LO = W'(RES + FP);
  localparam logic [W-1:0] SYNC_HI = W'(RES + FP + SYNC - 1);
  always_comb begin
    nxt = en ? (cnt == LAST ? '0 : cnt + 1'b1) : cnt;
    act = nxt < ACT_END;
    win = nxt >= SYNC_LO && nxt <= SYNC_HI;
  end
  // reset parks on the last blanking position so the first free-running edge lands on 0
  always_ff @(posedge clk)
    if (rst) cnt <= LAST;
    else cnt <= nxt;
endmodule

// File: rtl/display_timing.sv
// display_timing: pixel-clock raster timing generator (coordinates, syncs, de, line/frame strobes).
// Define DISPLAY_TIMING_PIPE_EN to delay hsync, vsync and de by one cycle behind sx/sy.
module display_timing import display_pkg::*; #(
  parameter int   H_RES  = TIMING_640X480_60.h.res,
  parameter int   H_FP   = TIMING_640X480_60.h.fp,
  parameter int   H_SYNC = TIMING_640X480_60.h.sync,
  parameter int   H_BP   = TIMING_640X480_60.h.bp,
  parameter int   V_RES  = TIMING_640X480_60.v.res,
  parameter int   V_FP   = TIMING_640X480_60.v.fp,
  parameter int   V_SYNC = TIMING_640X480_60.v.sync,
  parameter int   V_BP   = TIMING_640X480_60.v.bp,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   CORDW  = CORDW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);
  logic [CORDW-1:0] h_nxt, v_nxt;
  logic h_act, h_win, v_act, v_win, hs_q, vs_q, de_q;
  axis_counter #(.W(CORDW), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(sx), .nxt(h_nxt), .act(h_act), .win(h_win)
  );
  // the vertical axis advances only on horizontal wrap, so vsync changes only at sx==0
  axis_counter #(.W(CORDW), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst(rst), .en(h_nxt == '0), .cnt(sy), .nxt(v_nxt), .act(v_act), .win(v_win)
  );
  always_ff @(posedge clk)
    if (rst) begin
      hs_q        <= ~H_POL;
      vs_q        <= ~V_POL;
      de_q        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_q        <= h_win ? H_POL : ~H_POL;
      vs_q        <= v_win ? V_POL : ~V_POL;
      de_q        <= h_act && v_act;
      line_start  <= h_nxt == '0;
      frame_start <= h_nxt == '0 && v_nxt == '0;
    end
`ifdef DISPLAY_TIMING_PIPE_EN
  always_ff @(posedge clk)
    if (rst) begin
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      de    <= 1'b0;
    end else begin
      hsync <= hs_q;
      vsync <= vs_q;
      de    <= de_q;
    end
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign de    = de_q;
`endif
endmodule
